// File: rtl/gray_sobel3x3.sv
// RGB -> luma conversion, two-line buffer and 3x3 Sobel with a three-stage pipeline.
// Optional binarisation of the gradient modes when CONV_THRESH_EN is defined.
module gray_sobel3x3 #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned THRESH    = 256
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oGray,
  output logic [10:0]       oX_Cont,
  output logic [10:0]       oY_Cont,
  output logic              oDVAL
);

  localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned LW = DATA_W + 2;
  localparam int unsigned GW = DATA_W + 4;
  localparam logic [10:0] ColLast = 11'(IMG_WIDTH - 1);
  localparam logic [DATA_W-1:0] PixMax = '1;

  logic [10:0]       col_q, col_d, row_q, row_d, col_cur, row_cur;
  logic [1:0]        mode_q;
  logic [LW-1:0]     lsum;
  logic [DATA_W-1:0] luma_q;
  logic [10:0]       col1_q, row1_q, x2_q, y2_q;
  logic              v1_q, v2_q;
  logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] win_q [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]     ax, ay, mag;
  logic [DATA_W-1:0] gray_d;

  function automatic logic signed [GW-1:0] px(input logic [DATA_W-1:0] v);
    return $signed(GW'(v));
  endfunction

  always_comb begin
    col_cur = iSOF ? '0 : col_q;
    row_cur = iSOF ? '0 : row_q;
    col_d   = col_cur;
    row_d   = row_cur;
    if (iDVAL) begin
      if (col_cur == ColLast) begin
        col_d = '0;
        row_d = row_cur + 11'd1;
      end else begin
        col_d = col_cur + 11'd1;
      end
    end
  end

  assign lsum = LW'(iRed) + (LW'(iGreen) << 1) + LW'(iBlue);

  // S1: counters, mode latch and luma register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 2'b00;
      luma_q <= '0;
      col1_q <= '0;
      row1_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= iDVAL;
      if (iSOF) mode_q <= iMODE;
      if (iDVAL) begin
        luma_q <= lsum[LW-1:2];
        col1_q <= col_cur;
        row1_q <= row_cur;
      end
    end
  end

  // S2: line buffers and window shift; storage is not reset, gating hides stale data
  always_ff @(posedge iCLK) begin
    if (v1_q) begin
      lb0_mem[col1_q[AW-1:0]] <= luma_q;
      lb1_mem[col1_q[AW-1:0]] <= lb0_mem[col1_q[AW-1:0]];
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb1_mem[col1_q[AW-1:0]];
      win_q[1][2] <= lb0_mem[col1_q[AW-1:0]];
      win_q[2][2] <= luma_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2_q <= 1'b0;
      x2_q <= '0;
      y2_q <= '0;
    end else begin
      v2_q <= v1_q && (row1_q >= 11'd2) && (col1_q >= 11'd2);
      if (v1_q) begin
        x2_q <= col1_q - 11'd1;
        y2_q <= row1_q - 11'd1;
      end
    end
  end

  // S3: kernel, magnitude select and saturation
  always_comb begin
    gx = (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]))
       - (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]));
    gy = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
       - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
    ax = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay = gy[GW-1] ? GW'(-gy) : GW'(gy);
    case (mode_q)
      2'b01:   mag = ax;
      2'b10:   mag = ay;
      2'b11:   mag = ax + ay;
      default: mag = '0;
    endcase
    if (mode_q == 2'b00) begin
      gray_d = win_q[1][1];
    end else begin
`ifdef CONV_THRESH_EN
      gray_d = (mag >= GW'(THRESH)) ? PixMax : '0;
`else
      gray_d = (mag > GW'(PixMax)) ? PixMax : mag[DATA_W-1:0];
`endif
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL   <= 1'b0;
      oGray   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= v2_q;
      if (v2_q) begin
        oGray   <= gray_d;
        oX_Cont <= x2_q;
        oY_Cont <= y2_q;
      end
    end
  end

endmodule
